// File: rtl/add_share_arb_pkg.sv
// rtl/add_share_arb_pkg.sv - shared types and defaults for the adder-sharing arbiter
//   Provides default sizes, the in-flight tag type, the flush FSM state enum
//   and the round-robin pointer advance helper.
package add_pkg;
    localparam int N_REQ_DEF   = 4;
    localparam int WIDTH_DEF   = 15;
    localparam int ADD_LAT_DEF = 2;
    localparam int IDX_W       = $clog2(N_REQ_DEF);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Pointer moves to the requester after the one just served, wrapping to 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ_DEF - 1)) ? '0 : idx + 1'b1;
    endfunction
endpackage

// File: rtl/add_share_arb_if.sv
// rtl/add_share_arb_if.sv - requester-side bus of the adder-sharing arbiter
//   master: requesters (drive req_valid/req_x/req_y, see req_ready/rsp_valid/rsp_sum)
//   slave : arbiter    (the reverse)
interface add_share_arb_if
    import add_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ*WIDTH-1:0] req_y;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_sum;

    modport master (output req_valid, req_x, req_y, input req_ready, rsp_valid, rsp_sum);
    modport slave  (input req_valid, req_x, req_y, output req_ready, rsp_valid, rsp_sum);
endinterface

// File: rtl/add_1p.sv
// rtl/add_1p.sv - pipelined adder with fixed latency LAT, carry discarded
//   x_i, y_i : operands
//   sum_o    : (x_i + y_i) mod 2^WIDTH, LAT clock edges after the operands change
module add_1p
    import add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LAT   = ADD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] sum_o
);
    logic [WIDTH-1:0] pipe_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= x_i + y_i;
            for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign sum_o = pipe_q[LAT-1];
endmodule

// File: rtl/add_share_arb_rr_arb.sv
// rtl/add_share_arb_rr_arb.sv - combinational round-robin picker
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot grant (zero when no request)
//   idx_o   : index of the granted requester
//   any_o   : at least one request present
module rr_arb
    import add_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = IDX_W
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/add_share_arb.sv
// rtl/add_share_arb.sv - shares one pipelined adder among N_REQ requesters
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : requester bus (slave side): req_valid/x/y in, req_ready/rsp_valid/rsp_sum out
//   add_x_o/y_o  : registered operands to the external adder
//   add_sum_i    : adder result, ADD_LAT edges after the operands
//   flush_i      : level request to drain the adder
//   flush_done_o : drained and flush still requested
//   busy_o       : any tag in flight
module add_share_arb
    import add_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    add_share_arb_if.slave   bus,
    output logic [WIDTH-1:0] add_x_o,
    output logic [WIDTH-1:0] add_y_o,
    input  logic [WIDTH-1:0] add_sum_i,
    input  logic             flush_i,
    output logic             flush_done_o,
    output logic             busy_o
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] add_x_q, add_y_q, rsp_sum_q;
    logic [N_REQ-1:0] rsp_valid_q;
    tag_t             tag_q [ADD_LAT+1];

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] gidx;
    logic             gany;
    logic             grant_en;
    logic             hs;
    logic             busy;

    rr_arb #(.N(N_REQ), .IW(IDX_W)) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    // flush blocks grants in the same cycle it rises, before the FSM moves.
    assign grant_en      = (state_q == ST_RUN) && !flush_i;
    assign bus.req_ready = grant_en ? grant : '0;
    assign hs            = grant_en && gany;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= ADD_LAT; k++) busy = busy | tag_q[k].valid;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = hs ? next_ptr(gidx) : ptr_q;
        case (state_q)
            ST_RUN:   if (flush_i) state_d = ST_DRAIN;
            // A flush withdrawn mid-drain returns straight to RUN without a done phase.
            ST_DRAIN: if (!busy)   state_d = flush_i ? ST_DONE : ST_RUN;
            ST_DONE:  if (!flush_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            ptr_q       <= '0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_valid_q <= '0;
            for (int k = 0; k <= ADD_LAT; k++) tag_q[k] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (hs) begin
                add_x_q <= bus.req_x[gidx*WIDTH +: WIDTH];
                add_y_q <= bus.req_y[gidx*WIDTH +: WIDTH];
            end
            tag_q[0] <= tag_t'{valid: hs, idx: gidx};
            for (int k = 1; k <= ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
            // The last tag stage lines up with add_sum_i; both are registered together.
            rsp_valid_q <= tag_q[ADD_LAT].valid ? (N_REQ'(1) << tag_q[ADD_LAT].idx) : '0;
            rsp_sum_q   <= add_sum_i;
        end
    end

    assign add_x_o       = add_x_q;
    assign add_y_o       = add_y_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign busy_o        = busy;
    assign flush_done_o  = (state_q == ST_DONE) && flush_i;
endmodule

// File: tb/tb_add_share_arb.sv
// tb/tb_add_share_arb.sv - directed self-checking bench for add_share_arb with add_1p
module tb_add_share_arb;
    localparam int N = 4;
    localparam int W = 15;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] add_x, add_y, add_sum;
    logic         flush = 1'b0;
    logic         flush_done, busy;
    int           errors = 0;
    int           checks = 0;

    add_share_arb_if #(.N_REQ(N), .WIDTH(W)) bus ();

    add_share_arb #(.N_REQ(N), .WIDTH(W), .ADD_LAT(L)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .add_x_o      (add_x),
        .add_y_o      (add_y),
        .add_sum_i    (add_sum),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .busy_o       (busy)
    );

    add_1p #(.WIDTH(W), .LAT(L)) u_add (
        .clk   (clk),
        .rst_n (rst_n),
        .x_i   (add_x),
        .y_i   (add_y),
        .sum_o (add_sum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one requester alone, check grant, accept, then check the response 3 edges later.
    task automatic single(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_sum, input string tag);
        bus.req_valid = '0;
        bus.req_valid[i] = 1'b1;
        bus.req_x[i*W +: W] = x;
        bus.req_y[i*W +: W] = y;
        #1;
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << i));
        step();
        bus.req_valid = '0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_early1"}, 32'(bus.rsp_valid), 32'd0);
        step();
        chk({tag, "_early2"}, 32'(bus.rsp_valid), 32'd0);
        step();
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << i));
        chk({tag, "_rsp_sum"}, 32'(bus.rsp_sum), 32'(exp_sum));
        step();
        chk({tag, "_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] xs [N];
        logic [W-1:0] ys [N];
        logic [W-1:0] es [N];
        logic [N-1:0] seen;
        int           rsp_cnt;
        int           k;

        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_add_x", 32'(add_x), 32'd0);
        chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        single(0, 15'd10, 15'd0, 15'd10, "req0_10");
        single(2, 15'h07D2, 15'h07D2, 15'h0FA4, "req2_4004");
        single(1, 15'h7FFF, 15'h0001, 15'h0000, "req1_carry");
        single(1, 15'h4000, 15'h4000, 15'h0000, "req1_msb");

        // Reset one cycle after an accept: the tag must vanish.
        bus.req_valid = 4'b1000;
        bus.req_x[3*W +: W] = 15'h0123;
        bus.req_y[3*W +: W] = 15'h0456;
        step();
        bus.req_valid = '0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_add_x", 32'(add_x), 32'd0);
        step();
        rst_n = 1'b1;
        seen = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            seen = seen | bus.rsp_valid;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        chk("midrst_rsp_sum", 32'(bus.rsp_sum), 32'd0);

        // All four valid for eight grants, starting at req0 after reset.
        for (int i = 0; i < N; i++) begin
            xs[i] = W'(15'h1000 * (i + 1) + i);
            ys[i] = W'(15'h0111 * (i + 1));
            es[i] = xs[i] + ys[i];
            bus.req_x[i*W +: W] = xs[i];
            bus.req_y[i*W +: W] = ys[i];
        end
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 13; c++) begin
            if (c == 8) bus.req_valid = '0;
            #1;
            chk($sformatf("rr_grant_%0d", c), 32'(bus.req_ready), (c < 8) ? 32'(1 << (c % 4)) : 32'd0);
            if (c >= 4 && c < 12) begin
                chk($sformatf("rr_rsp_valid_%0d", c), 32'(bus.rsp_valid), 32'(1 << ((c - 4) % 4)));
                chk($sformatf("rr_rsp_sum_%0d", c), 32'(bus.rsp_sum), 32'(es[(c - 4) % 4]));
            end else begin
                chk($sformatf("rr_rsp_idle_%0d", c), 32'(bus.rsp_valid), 32'd0);
            end
            step();
        end

        // Two accepts, then flush while all requests stay valid.
        bus.req_valid = 4'b1111;
        #1;
        chk("fl_grant0", 32'(bus.req_ready), 32'b0001);
        step();
        chk("fl_grant1", 32'(bus.req_ready), 32'b0010);
        step();
        flush = 1'b1;
        #1;
        chk("fl_ready_now", 32'(bus.req_ready), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        rsp_cnt = 0;
        seen = '0;
        k = 0;
        while (!flush_done && k < 20) begin
            step();
            if (bus.req_ready != '0) seen = seen | bus.req_ready;
            if (bus.rsp_valid != '0) begin
                chk($sformatf("fl_rsp_order_%0d", rsp_cnt), 32'(bus.rsp_valid), 32'(1 << rsp_cnt));
                rsp_cnt++;
            end
            if (!busy && rsp_cnt < 2) begin
                chk("fl_busy_early", 32'(busy), 32'd1);
            end
            k++;
        end
        chk("fl_done_reached", 32'(flush_done), 32'd1);
        chk("fl_no_grant", 32'(seen), 32'd0);
        chk("fl_rsp_count", 32'(rsp_cnt), 32'd2);
        chk("fl_idle", 32'(busy), 32'd0);
        flush = 1'b0;
        #1;
        chk("fl_done_drop", 32'(flush_done), 32'd0);
        chk("fl_done_no_grant", 32'(bus.req_ready), 32'd0);
        step();
        chk("fl_resume_ptr", 32'(bus.req_ready), 32'b0100);
        bus.req_valid = '0;
        for (int c = 0; c < 5; c++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
